// File: rtl/reg_bus_arbiter.sv
// Two-requester round-robin arbiter sharing one register-block bus port.
// Serializes accesses, routes responses to the owner, and forces an error on downstream timeout.
module reg_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req_0,
  input  logic                  req_is_wr_0,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [DATA_WIDTH-1:0] wr_data_0,
  input  logic [DATA_WIDTH-1:0] wr_biten_0,
  output logic                  ready_0,
  output logic [DATA_WIDTH-1:0] rd_data_0,
  output logic                  err_0,

  input  logic                  req_1,
  input  logic                  req_is_wr_1,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] wr_data_1,
  input  logic [DATA_WIDTH-1:0] wr_biten_1,
  output logic                  ready_1,
  output logic [DATA_WIDTH-1:0] rd_data_1,
  output logic                  err_1,

  output logic                  bus_req,
  output logic                  bus_req_is_wr,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wr_data,
  output logic [DATA_WIDTH-1:0] bus_wr_biten,
  input  logic                  bus_ready,
  input  logic [DATA_WIDTH-1:0] bus_rd_data,
  input  logic                  bus_err,

  output logic [1:0]            grant,
  output logic                  timeout_evt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int unsigned   TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            rr_last_q, rr_last_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic            sel;
  logic            req_g;
  logic            rsp_ready;
  logic            rsp_err;
  logic [DATA_WIDTH-1:0] rsp_data;

  assign sel   = grant_q[1];
  assign req_g = sel ? req_1 : req_0;
  assign grant = grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_last_q <= 1'b1;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_last_d     = rr_last_q;
    tmo_cnt_d     = tmo_cnt_q;
    bus_req       = 1'b0;
    bus_req_is_wr = 1'b0;
    bus_addr      = '0;
    bus_wr_data   = '0;
    bus_wr_biten  = '0;
    timeout_evt   = 1'b0;
    rsp_ready     = 1'b0;
    rsp_err       = 1'b0;
    rsp_data      = '0;

    unique case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (req_0 && req_1) grant_d = rr_last_q ? 2'b01 : 2'b10;
        else if (req_0)     grant_d = 2'b01;
        else if (req_1)     grant_d = 2'b10;
        if (req_0 || req_1) state_d = BUSY;
      end
      BUSY: begin
        bus_req       = 1'b1;
        bus_req_is_wr = sel ? req_is_wr_1 : req_is_wr_0;
        bus_addr      = sel ? addr_1      : addr_0;
        bus_wr_data   = sel ? wr_data_1   : wr_data_0;
        bus_wr_biten  = sel ? wr_biten_1  : wr_biten_0;
        // Resolution order: downstream completion, then timeout, then requester abort.
        if (bus_ready) begin
          rsp_ready = 1'b1;
          rsp_data  = bus_rd_data;
          rsp_err   = bus_err;
          rr_last_d = sel;
          grant_d   = '0;
          state_d   = IDLE;
        end else if ((TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST)) begin
          rsp_ready   = 1'b1;
          rsp_err     = 1'b1;
          timeout_evt = 1'b1;
          rr_last_d   = sel;
          grant_d     = '0;
          state_d     = IDLE;
        end else if (!req_g) begin
          bus_req = 1'b0;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_0   = rsp_ready & ~sel;
    ready_1   = rsp_ready &  sel;
    err_0     = rsp_err   & ~sel;
    err_1     = rsp_err   &  sel;
    rd_data_0 = sel ? '0 : rsp_data;
    rd_data_1 = sel ? rsp_data : '0;
  end

endmodule
